// File: rtl/clk_div_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_gen_if
// Purpose  : Bundles the control and clock-output signals of clk_div_gen.
//            The slave side is the divider. The master side is the
//            front-panel / CPU logic: it drives the mode, the divisors,
//            step_req and clr_cycles, and it receives the generated clocks,
//            the tick strobes and the cycle count.
// Signals  : mode[1:0], div_fast, div_slow, disp_div, step_req, clr_cycles
//            (master -> slave); cpu_clk, cpu_tick, disp_clk, disp_tick,
//            cycles (slave -> master).
// Revision : 1.0 - initial release
// ============================================================================
interface clk_div_gen_if #(
  parameter int CNT_W = 32,
  parameter int CYC_W = 16
);
  logic [1:0]       mode;
  logic [CNT_W-1:0] div_fast;
  logic [CNT_W-1:0] div_slow;
  logic [CNT_W-1:0] disp_div;
  logic             step_req;
  logic             clr_cycles;
  logic             cpu_clk;
  logic             cpu_tick;
  logic             disp_clk;
  logic             disp_tick;
  logic [CYC_W-1:0] cycles;

  modport master (
    output mode, div_fast, div_slow, disp_div, step_req, clr_cycles,
    input  cpu_clk, cpu_tick, disp_clk, disp_tick, cycles
  );

  modport slave (
    input  mode, div_fast, div_slow, disp_div, step_req, clr_cycles,
    output cpu_clk, cpu_tick, disp_clk, disp_tick, cycles
  );
endinterface
`default_nettype wire

// File: rtl/clk_div_gen.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_gen
// Purpose  : Generates the CPU clock and the display clock.
//            The CPU clock has four run modes: fast divide, slow divide,
//            single-step and halt. The display clock runs free and does not
//            depend on the mode. Both divisors can be changed at run time.
//            Each channel toggles every D+1 Sys_Clk cycles, so its period is
//            2*(D+1) cycles. A new divisor is taken only at a terminal count.
//            The block also keeps a clearable count of cpu_clk rising edges.
// Ports    : Sys_Clk - system clock
//            rst_n   - synchronous reset, active-low
//            bus     - clk_div_gen_if.slave (mode, divisors, step_req,
//                      clr_cycles in; cpu_clk/tick, disp_clk/tick, cycles out)
// Options  : CLK_DIV_CYC_SAT_EN - when defined, cycles stops at its
//            all-ones value instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_gen #(
  parameter int CNT_W    = 32,
  parameter int CYC_W    = 16,
  parameter int DISP_DEF = 200000
) (
  input wire           Sys_Clk,
  input wire           rst_n,
  clk_div_gen_if.slave bus
);
  localparam logic [1:0]       c_mode_fast = 2'b00;
  localparam logic [1:0]       c_mode_slow = 2'b01;
  localparam logic [1:0]       c_mode_step = 2'b10;
  localparam logic [CNT_W-1:0] c_disp_def  = CNT_W'(DISP_DEF);
`ifdef CLK_DIV_CYC_SAT_EN
  localparam logic [CYC_W-1:0] c_cyc_max   = '1;
`endif

  logic [1:0]       r_mode_q;
  logic             r_step_q;
  logic [CNT_W-1:0] r_cpu_cnt;
  logic [CNT_W-1:0] r_cpu_shadow;
  logic             r_cpu_clk;
  logic             r_cpu_tick;
  logic [CNT_W-1:0] r_disp_cnt;
  logic [CNT_W-1:0] r_disp_shadow;
  logic             r_disp_clk;
  logic             r_disp_tick;
  logic [CYC_W-1:0] r_cycles;

  logic [CNT_W-1:0] w_cpu_div;
  logic [CNT_W-1:0] w_disp_div;
  logic             w_mode_chg;
  logic             w_cpu_term;
  logic             w_disp_term;
  logic             w_step_edge;
  logic             w_cpu_rise;

  // The step and halt modes have no divisor of their own. Their shadow value
  // is never used, because leaving either mode is a mode change, and a mode
  // change reloads the shadow.
  assign w_cpu_div   = (bus.mode == c_mode_fast) ? bus.div_fast : bus.div_slow;
  assign w_disp_div  = (bus.disp_div == '0) ? c_disp_def : bus.disp_div;
  assign w_mode_chg  = (bus.mode != r_mode_q);
  assign w_cpu_term  = (r_cpu_cnt == r_cpu_shadow);
  assign w_disp_term = (r_disp_cnt == r_disp_shadow);
  assign w_step_edge = bus.step_req & ~r_step_q;

  // A rising edge of cpu_clk is the only event that counts as a cycle.
  // The forced low on entry to step/halt is not a rising edge.
  always_comb begin
    w_cpu_rise = 1'b0;
    if (!w_mode_chg) begin
      case (bus.mode)
        c_mode_fast, c_mode_slow: w_cpu_rise = w_cpu_term & ~r_cpu_clk;
        c_mode_step:              w_cpu_rise = w_step_edge & ~r_cpu_clk;
        default:                  w_cpu_rise = 1'b0;
      endcase
    end
  end

  always_ff @(posedge Sys_Clk) begin
    if (!rst_n) begin
      // Loading the current mode here means releasing reset does not look
      // like a mode change.
      r_mode_q     <= bus.mode;
      r_step_q     <= 1'b0;
      r_cpu_cnt    <= '0;
      r_cpu_shadow <= w_cpu_div;
      r_cpu_clk    <= 1'b0;
      r_cpu_tick   <= 1'b0;
    end else begin
      // step_req is registered in every mode. A level held through halt
      // therefore cannot appear as a fresh edge when step mode is entered.
      r_mode_q   <= bus.mode;
      r_step_q   <= bus.step_req;
      r_cpu_tick <= w_cpu_rise;
      if (w_mode_chg) begin
        r_cpu_cnt    <= '0;
        r_cpu_shadow <= w_cpu_div;
        if (bus.mode[1]) begin
          r_cpu_clk <= 1'b0;
        end
      end else begin
        case (bus.mode)
          c_mode_fast, c_mode_slow: begin
            if (w_cpu_term) begin
              r_cpu_cnt    <= '0;
              r_cpu_shadow <= w_cpu_div;
              r_cpu_clk    <= ~r_cpu_clk;
            end else begin
              r_cpu_cnt <= r_cpu_cnt + 1'b1;
            end
          end
          c_mode_step: begin
            if (r_cpu_clk) begin
              r_cpu_clk <= 1'b0;
            end else if (w_step_edge) begin
              r_cpu_clk <= 1'b1;
            end
          end
          default: r_cpu_clk <= 1'b0;
        endcase
      end
    end
  end

  // Clear has priority over an increment in the same cycle.
  always_ff @(posedge Sys_Clk) begin
    if (!rst_n || bus.clr_cycles) begin
      r_cycles <= '0;
    end else if (w_cpu_rise) begin
`ifdef CLK_DIV_CYC_SAT_EN
      if (r_cycles != c_cyc_max) begin
        r_cycles <= r_cycles + 1'b1;
      end
`else
      r_cycles <= r_cycles + 1'b1;
`endif
    end
  end

  always_ff @(posedge Sys_Clk) begin
    if (!rst_n) begin
      r_disp_cnt    <= '0;
      r_disp_shadow <= w_disp_div;
      r_disp_clk    <= 1'b0;
      r_disp_tick   <= 1'b0;
    end else begin
      r_disp_tick <= w_disp_term;
      if (w_disp_term) begin
        r_disp_cnt    <= '0;
        r_disp_shadow <= w_disp_div;
        r_disp_clk    <= ~r_disp_clk;
      end else begin
        r_disp_cnt <= r_disp_cnt + 1'b1;
      end
    end
  end

  assign bus.cpu_clk   = r_cpu_clk;
  assign bus.cpu_tick  = r_cpu_tick;
  assign bus.disp_clk  = r_disp_clk;
  assign bus.disp_tick = r_disp_tick;
  assign bus.cycles    = r_cycles;
endmodule
`default_nettype wire

// File: tb/tb_clk_div_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_gen
// Purpose  : Self-checking bench for clk_div_gen. A reference model tracks
//            how many cycles are left in each half-period. It runs in
//            lockstep with the DUT, and each scenario task also checks
//            hand-derived timing expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_gen;
  localparam int CNT_W    = 32;
  localparam int CYC_W    = 8;
  localparam int DISP_DEF = 50;
  localparam int LIM      = 1 << CYC_W;
`ifdef CLK_DIV_CYC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic Sys_Clk = 1'b0;
  logic rst_n   = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  clk_div_gen_if #(.CNT_W(CNT_W), .CYC_W(CYC_W)) bus ();

  clk_div_gen #(.CNT_W(CNT_W), .CYC_W(CYC_W), .DISP_DEF(DISP_DEF)) dut (
    .Sys_Clk (Sys_Clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 Sys_Clk = ~Sys_Clk;

  // ---------------- reference model ----------------
  longint     m_left, m_dleft;   // cycles left in the current half-period
  logic       m_clk, m_tick, m_dclk, m_dtick, m_step_prev, m_rise;
  logic [1:0] m_mode_prev;
  int         m_cycles;

  function automatic longint cpu_phase(input logic [1:0] md);
    if (md == 2'b00) return longint'(bus.div_fast) + 1;
    return longint'(bus.div_slow) + 1;
  endfunction

  function automatic longint disp_phase();
    if (bus.disp_div == 0) return longint'(DISP_DEF) + 1;
    return longint'(bus.disp_div) + 1;
  endfunction

  always_comb begin
    m_rise = 1'b0;
    if (rst_n && bus.mode == m_mode_prev) begin
      if (!bus.mode[1]) m_rise = (m_left <= 1) && !m_clk;
      else if (bus.mode == 2'b10) m_rise = !m_clk && bus.step_req && !m_step_prev;
    end
  end

  always @(posedge Sys_Clk) begin
    m_tick  <= 1'b0;
    m_dtick <= 1'b0;
    if (!rst_n) begin
      m_left <= cpu_phase(bus.mode);
      m_dleft <= disp_phase();
      m_clk <= 1'b0; m_dclk <= 1'b0; m_cycles <= 0;
      m_mode_prev <= bus.mode; m_step_prev <= 1'b0;
    end else begin
      m_mode_prev <= bus.mode;
      m_step_prev <= bus.step_req;
      if (m_dleft <= 1) begin
        m_dclk <= ~m_dclk; m_dtick <= 1'b1; m_dleft <= disp_phase();
      end else m_dleft <= m_dleft - 1;
      if (bus.clr_cycles) m_cycles <= 0;
      else if (m_rise) m_cycles <= SAT ? ((m_cycles == LIM - 1) ? m_cycles : m_cycles + 1)
                                       : (m_cycles + 1) % LIM;
      if (bus.mode != m_mode_prev) begin
        m_left <= cpu_phase(bus.mode);
        if (bus.mode[1]) m_clk <= 1'b0;
      end else if (!bus.mode[1]) begin
        if (m_left <= 1) begin
          m_clk <= ~m_clk; m_left <= cpu_phase(bus.mode);
          if (!m_clk) m_tick <= 1'b1;
        end else m_left <= m_left - 1;
      end else if (bus.mode == 2'b10) begin
        if (m_clk) m_clk <= 1'b0;
        else if (bus.step_req && !m_step_prev) begin m_clk <= 1'b1; m_tick <= 1'b1; end
      end else m_clk <= 1'b0;
    end
  end

  logic [CYC_W+3:0] dut_vec, mdl_vec;
  logic [CYC_W-1:0] m_cyc_v;
  assign m_cyc_v = m_cycles[CYC_W-1:0];
  assign dut_vec = {bus.cpu_clk, bus.cpu_tick, bus.disp_clk, bus.disp_tick, bus.cycles};
  assign mdl_vec = {m_clk, m_tick, m_dclk, m_dtick, m_cyc_v};

  task automatic step_clk();
    @(posedge Sys_Clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic e_clk, e_tick;
    rst_n = 1'b0;
    bus.mode = 2'b00; bus.div_fast = 4; bus.div_slow = 9;
    bus.disp_div = $urandom_range(5, 15); bus.step_req = 1'b0; bus.clr_cycles = 1'b0;
    repeat (3) step_clk();
    n_checks++;
    if (dut_vec !== '0) begin n_errors++; $display("FAIL reset_state: got %h expected 0", dut_vec); end
    rst_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step_clk();
      n_checks++;
      if (dut_vec !== mdl_vec) begin n_errors++; $display("FAIL reset_lockstep k=%0d: got %h expected %h", k, dut_vec, mdl_vec); end
      e_clk  = (k >= 5) && (((k - 5) / 5) % 2 == 0);
      e_tick = (k >= 5) && ((k - 5) % 10 == 0);
      n_checks++;
      if ({bus.cpu_clk, bus.cpu_tick} !== {e_clk, e_tick}) begin
        n_errors++; $display("FAIL fast_timing k=%0d: got %b%b expected %b%b", k, bus.cpu_clk, bus.cpu_tick, e_clk, e_tick);
      end
    end
    n_checks++;
    if (bus.cycles !== CYC_W'(3)) begin n_errors++; $display("FAIL cycles_after_3_rises: got %0d expected 3", bus.cycles); end
  endtask

  task automatic test_reset_mid_phase();
    rst_n = 1'b0; step_clk(); rst_n = 1'b1;
    repeat (8) begin
      step_clk();
      n_checks++;
      if (dut_vec !== mdl_vec) begin n_errors++; $display("FAIL midrst_pre: got %h expected %h", dut_vec, mdl_vec); end
    end
    n_checks++;
    if (bus.cpu_clk !== 1'b1) begin n_errors++; $display("FAIL midrst_clk_high: got %b expected 1", bus.cpu_clk); end
    rst_n = 1'b0; step_clk();
    n_checks++;
    if (dut_vec !== '0) begin n_errors++; $display("FAIL midrst_state: got %h expected 0", dut_vec); end
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step_clk();
      n_checks++;
      if (bus.cpu_clk !== ((k >= 5) && (k <= 9))) begin
        n_errors++; $display("FAIL midrst_first_rise k=%0d: got %b expected %b", k, bus.cpu_clk, (k >= 5) && (k <= 9));
      end
    end
  endtask

  task automatic test_slow_div_change();
    logic last;
    bit   found = 1'b0;
    int   cnt = 0;
    int   q[$];
    bus.mode = 2'b01; bus.div_slow = 9;
    last = bus.cpu_clk;
    for (int i = 0; i < 40; i++) begin
      step_clk();
      n_checks++;
      if (dut_vec !== mdl_vec) begin n_errors++; $display("FAIL slow_lockstep: got %h expected %h", dut_vec, mdl_vec); end
      if (bus.cpu_clk !== last) begin found = 1'b1; break; end
    end
    n_checks++;
    if (!found) begin n_errors++; $display("FAIL slow_first_toggle: got none expected toggle within 40"); end
    last = bus.cpu_clk;
    for (int i = 0; i < 30; i++) begin
      step_clk();
      cnt++;
      if (i == 3) bus.div_slow = 1;
      n_checks++;
      if (dut_vec !== mdl_vec) begin n_errors++; $display("FAIL slow_lockstep2: got %h expected %h", dut_vec, mdl_vec); end
      if (bus.cpu_clk !== last) begin q.push_back(cnt); cnt = 0; last = bus.cpu_clk; end
    end
    n_checks++;
    if (q.size() < 5) begin n_errors++; $display("FAIL slow_phase_count: got %0d expected >=5", q.size()); end
    else begin
      n_checks++;
      if (q[0] != 10) begin n_errors++; $display("FAIL slow_old_phase: got %0d expected 10", q[0]); end
      for (int i = 1; i < q.size(); i++) begin
        n_checks++;
        if (q[i] != 2) begin n_errors++; $display("FAIL slow_new_phase %0d: got %0d expected 2", i, q[i]); end
      end
    end
  endtask

  task automatic test_step();
    int ticks = 0;
    logic [CYC_W-1:0] cyc0;
    bus.mode = 2'b10; bus.step_req = 1'b0;
    repeat (3) step_clk();
    cyc0 = bus.cycles;
    for (int p = 0; p < 3; p++) begin
      bus.step_req = 1'b1;
      for (int j = 1; j <= 3; j++) begin
        step_clk();
        ticks += int'(bus.cpu_tick);
        n_checks++;
        if ({bus.cpu_clk, bus.cpu_tick} !== {(j == 1), (j == 1)}) begin
          n_errors++; $display("FAIL step_pulse p=%0d j=%0d: got %b%b expected %b%b", p, j, bus.cpu_clk, bus.cpu_tick, j == 1, j == 1);
        end
      end
      bus.step_req = 1'b0;
      repeat (5) begin
        step_clk();
        ticks += int'(bus.cpu_tick);
        n_checks++;
        if (dut_vec !== mdl_vec) begin n_errors++; $display("FAIL step_lockstep: got %h expected %h", dut_vec, mdl_vec); end
      end
    end
    n_checks++;
    if (ticks != 3) begin n_errors++; $display("FAIL step_tick_count: got %0d expected 3", ticks); end
    n_checks++;
    if (bus.cycles !== CYC_W'(cyc0 + 3)) begin n_errors++; $display("FAIL step_cycles: got %0d expected %0d", bus.cycles, CYC_W'(cyc0 + 3)); end
    ticks = 0;
    bus.step_req = 1'b1;
    repeat (50) begin step_clk(); ticks += int'(bus.cpu_tick); end
    bus.step_req = 1'b0;
    step_clk();
    n_checks++;
    if (ticks != 1) begin n_errors++; $display("FAIL step_held_level: got %0d expected 1", ticks); end
  endtask

  task automatic test_halt();
    bit found = 1'b0;
    int ticks = 0, dcnt = 0, n_dt = 0;
    logic [CYC_W-1:0] cyc0;
    bus.mode = 2'b00; bus.div_fast = $urandom_range(2, 6); bus.disp_div = 0;
    for (int i = 0; i < 40; i++) begin
      step_clk();
      if (bus.cpu_clk === 1'b1) begin found = 1'b1; break; end
    end
    n_checks++;
    if (!found) begin n_errors++; $display("FAIL halt_wait_high: got none expected cpu_clk=1 within 40"); end
    cyc0 = bus.cycles;
    bus.mode = 2'b11;
    step_clk();
    n_checks++;
    if ({bus.cpu_clk, bus.cycles} !== {1'b0, cyc0}) begin
      n_errors++; $display("FAIL halt_entry: got %b/%0d expected 0/%0d", bus.cpu_clk, bus.cycles, cyc0);
    end
    for (int i = 0; i < 160; i++) begin
      bus.step_req = 1'($urandom_range(0, 1));
      step_clk();
      ticks += int'(bus.cpu_tick) + int'(bus.cpu_clk);
      n_checks++;
      if (dut_vec !== mdl_vec) begin n_errors++; $display("FAIL halt_lockstep: got %h expected %h", dut_vec, mdl_vec); end
      dcnt++;
      if (bus.disp_tick === 1'b1) begin
        if (n_dt > 0) begin
          n_checks++;
          if (dcnt != DISP_DEF + 1) begin n_errors++; $display("FAIL disp_default_period: got %0d expected %0d", dcnt, DISP_DEF + 1); end
        end
        n_dt++; dcnt = 0;
      end
    end
    n_checks++;
    if (ticks != 0 || bus.cycles !== cyc0) begin
      n_errors++; $display("FAIL halt_frozen: got ticks=%0d cycles=%0d expected 0/%0d", ticks, bus.cycles, cyc0);
    end
    n_checks++;
    if (n_dt < 3) begin n_errors++; $display("FAIL disp_running: got %0d ticks expected >=3", n_dt); end
    bus.step_req = 1'b1;
    repeat (4) step_clk();
    bus.mode = 2'b10;
    ticks = 0;
    repeat (10) begin step_clk(); ticks += int'(bus.cpu_tick); end
    bus.step_req = 1'b0;
    n_checks++;
    if (ticks != 0) begin n_errors++; $display("FAIL halt_no_stale_step: got %0d expected 0", ticks); end
  endtask

  task automatic test_wrap_and_clear();
    bit found = 1'b0;
    bus.mode = 2'b00; bus.div_fast = 0; bus.clr_cycles = 1'b1;
    step_clk();
    bus.clr_cycles = 1'b0;
    n_checks++;
    if (bus.cycles !== '0) begin n_errors++; $display("FAIL clr_alone: got %0d expected 0", bus.cycles); end
    for (int i = 0; i < 2 * LIM + 10; i++) begin
      step_clk();
      n_checks++;
      if (dut_vec !== mdl_vec) begin n_errors++; $display("FAIL wrap_lockstep: got %h expected %h", dut_vec, mdl_vec); end
      if (bus.cycles === CYC_W'(LIM - 1)) begin found = 1'b1; break; end
    end
    n_checks++;
    if (!found) begin n_errors++; $display("FAIL wrap_reach_max: got %0d expected %0d", bus.cycles, LIM - 1); end
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step_clk();
      if (bus.cpu_tick === 1'b1) begin found = 1'b1; break; end
    end
    n_checks++;
    if (!found || bus.cycles !== (SAT ? CYC_W'(LIM - 1) : CYC_W'(0))) begin
      n_errors++; $display("FAIL wrap_value: got %0d expected %0d", bus.cycles, SAT ? LIM - 1 : 0);
    end
    repeat (10) step_clk();
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.cpu_clk === 1'b0) begin found = 1'b1; break; end
      step_clk();
    end
    bus.clr_cycles = 1'b1;
    step_clk();
    bus.clr_cycles = 1'b0;
    n_checks++;
    if (!found || {bus.cpu_tick, bus.cycles} !== {1'b1, CYC_W'(0)}) begin
      n_errors++; $display("FAIL clr_wins: got tick=%b cycles=%0d expected 1/0", bus.cpu_tick, bus.cycles);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 24) == 0) bus.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 14) == 0) bus.div_fast = $urandom_range(0, 7);
      if ($urandom_range(0, 14) == 0) bus.div_slow = $urandom_range(0, 7);
      if ($urandom_range(0, 39) == 0) bus.disp_div = $urandom_range(0, 10);
      if ($urandom_range(0, 2) == 0) bus.step_req = ~bus.step_req;
      bus.clr_cycles = ($urandom_range(0, 29) == 0);
      step_clk();
      n_checks++;
      if (dut_vec !== mdl_vec) begin n_errors++; $display("FAIL random_lockstep i=%0d: got %h expected %h", i, dut_vec, mdl_vec); end
    end
    bus.clr_cycles = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.mode = 2'b00; bus.div_fast = 4; bus.div_slow = 9; bus.disp_div = 0;
    bus.step_req = 1'b0; bus.clr_cycles = 1'b0;
    test_reset();
    test_reset_mid_phase();
    test_slow_div_change();
    test_step();
    test_halt();
    test_wrap_and_clear();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/clk_div_gen.md
Name: clk_div_gen

Overview:
- Parametrised successor to the single-channel board divider.
- Generates a CPU clock with four run modes (fast divide, slow divide, single-step, halt) and an independent free-running display clock.
- Divisors are runtime-programmable; each clock output has a matching one-cycle tick strobe.
- Provides a clearable CPU cycle counter. Sits between the board oscillator, the front-panel switches and the CPU/LED-display logic.

Parameters:
- CNT_W, 32: width of the divider counters and divisor inputs.
- CYC_W, 16: width of the cycle counter.
- DISP_DEF, 200000: display divisor applied while disp_div == 0.

Ports:
- Sys_Clk  in  1  system clock (100 MHz on board).
- rst_n  in  1  synchronous reset, active-low.
- mode  in  2  CPU clock mode: 00 fast, 01 slow, 10 step, 11 halt.
- div_fast  in  CNT_W  fast-mode divisor.
- div_slow  in  CNT_W  slow-mode divisor.
- disp_div  in  CNT_W  display divisor (0 selects DISP_DEF).
- step_req  in  1  step button, synchronised level; its rising edge requests one step.
- clr_cycles  in  1  synchronous clear of cycles.
- cpu_clk  out  1  CPU clock (register output).
- cpu_tick  out  1  one-Sys_Clk pulse on each cpu_clk rising edge.
- disp_clk  out  1  display clock.
- disp_tick  out  1  one-Sys_Clk pulse on each disp_clk toggle.
- cycles  out  CYC_W  count of cpu_clk rising edges.

Behaviour:
- Reset: on any Sys_Clk edge with rst_n == 0:
  - all outputs and counters go to 0;
  - the step edge-detect register goes to 0;
  - the CPU shadow divisor loads the divisor for the current mode;
  - the display shadow divisor loads disp_div (or DISP_DEF).
  - rst_n dominates every other input.
- Divider rule (both channels):
  - Counter cnt increments each edge.
  - When cnt == shadow: cnt <= 0, clock output toggles, shadow reloads from the current input.
  - Output period = 2*(D+1) Sys_Clk cycles. D = 0 toggles every edge.
  - Divisor changes take effect only at the next terminal count; there are no runt phases.
- Fast/slow modes:
  - Divider runs with div_fast or div_slow.
  - cpu_tick = 1 in the cycle cpu_clk goes 0->1; cycles increments in that same cycle.
- Mode change (mode differs from its value registered on the previous edge), in the same edge:
  - CPU cnt <= 0 and shadow reloads from the new mode's divisor;
  - cpu_clk keeps its level when the new mode is fast/slow;
  - cpu_clk <= 0 when the new mode is step/halt. This falling edge is not counted.
- Step mode:
  - A step_req 0->1 edge is detected at edge N (compares against its registered copy).
  - cpu_clk = 1 and cpu_tick = 1 for exactly the cycle after N, then cpu_clk returns to 0; cycles increments once.
  - Level held high produces no further steps. Edges while cpu_clk is high cannot occur (minimum 2-cycle spacing).
- Halt mode: cpu_clk held 0, no ticks, cycles frozen. step_req is ignored but still registered, so no stale edge fires on entering step mode.
- Display channel:
  - Free-running in all modes, independent of mode and clr_cycles.
  - disp_tick pulses on every disp_clk toggle.
- Cycle counter:
  - Wraps from 2^CYC_W-1 to 0.
  - clr_cycles in the same cycle as an increment: clear wins, so cycles = 0.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: CLK_DIV_CYC_SAT_EN.
- Defined: cycles saturates at 2^CYC_W-1 and holds there until clr_cycles or reset.
- Undefined: cycles wraps to 0 as described above.

Test Plan:
- Reset, mode=00, div_fast=4, release rst_n → cpu_clk rises on the 5th edge after release, period 10 cycles, 50% duty; cpu_tick 1-cycle pulse at each rise; cycles = 3 after 3 rises.
- mode=01, div_slow=9, change div_slow to 1 mid-phase → current phase completes at 10 cycles; subsequent phases are 2 cycles; no phase is shorter than 2.
- mode=10, three step_req pulses (each 3 cycles high, 5 low) → three 1-cycle cpu_clk highs, each 1 cycle after the detected edge; cycles = 3; step_req held high 50 cycles → 1 step only.
- Switch 00→11 while cpu_clk=1 → cpu_clk 0 the next cycle, cycles unchanged; hold 100 cycles → no ticks; disp_clk keeps toggling every 200001 cycles with disp_div=0.
- cycles=0xFFFF with a rising edge pending → wraps to 0x0000 (macro undefined) or stays 0xFFFF (CLK_DIV_CYC_SAT_EN defined); clr_cycles asserted on an increment cycle → cycles = 0.
- rst_n low mid-phase with cnt=3, cpu_clk=1 → next edge: all outputs 0, counters 0; after release, the first cpu_clk rise lands exactly as in the first scenario.
